polysub_sequencer: RTL

Controller that runs an element-wise modular subtraction C[k] = (A[k] − B[k]) mod q over two coefficient banks and writes the results to a third bank. It sits between the NTT top-level control and the shared coefficient memories. It drives one `modular_subtractor` instance and aligns the memory read latency with the write-back, so the NTT top level sees a single start/done operation per vector.

---
 rtl/ntt_pkg.sv | 28 ++
 rtl/polysub_sequencer_if.sv | 40 ++++
 rtl/modular_subtractor.sv | 39 +++
 rtl/polysub_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT definitions: coefficient width, modulus table and the
// polysub_sequencer state encoding.
package ntt_pkg;

  localparam int COEF_W = 30;

  // Modulus for MOD_INDEX = 0
  localparam logic [COEF_W-1:0] Q_IDX0 = 30'd1063321601;

  // Maps a modulus selector to its prime; unknown selectors fall back to index 0
  function automatic logic [COEF_W-1:0] get_q(input int unsigned idx);
    logic [COEF_W-1:0] q;
    case (idx)
      32'd0:   q = Q_IDX0;
      default: q = Q_IDX0;
    endcase
    return q;
  endfunction

  // Sequencer FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/polysub_sequencer_if.sv
// Bus bundle between the NTT top level / coefficient banks and the
// polysub_sequencer. The swap input exists only when POLYSUB_SWAP_EN is defined.
interface polysub_sequencer_if #(
  parameter int ADDR_W = 10
);

  logic                        start;
  logic [ADDR_W-1:0]           len_m1;
  logic                        busy;
  logic                        done;
  logic                        rd_en;
  logic [ADDR_W-1:0]           rd_addr;
  logic [ntt_pkg::COEF_W-1:0]  a_data;
  logic [ntt_pkg::COEF_W-1:0]  b_data;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ntt_pkg::COEF_W-1:0]  wr_data;
`ifdef POLYSUB_SWAP_EN
  logic                        swap;
`endif

  // Controller / memory side: drives commands and read data
  modport master (
`ifdef POLYSUB_SWAP_EN
    output swap,
`endif
    output start, len_m1, a_data, b_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  // Sequencer side
  modport slave (
`ifdef POLYSUB_SWAP_EN
    input  swap,
`endif
    input  start, len_m1, a_data, b_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/modular_subtractor.sv
// Registered modular subtractor: o_y = (i_a - i_b) mod q, one cycle latency.
// Operands are assumed to be already reduced (< q). The result register has
// no reset; its content is only meaningful when the caller qualifies it.
module modular_subtractor
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0
) (
  input  logic              clk,
  input  logic [COEF_W-1:0] i_a,
  input  logic [COEF_W-1:0] i_b,
  output logic [COEF_W-1:0] o_y
);

  localparam logic [COEF_W-1:0] Q = get_q(MOD_INDEX);

  logic [COEF_W:0]   w_diff;
  logic [COEF_W-1:0] w_res;
  logic [COEF_W-1:0] r_y;

  // Subtract with an extra borrow bit; on borrow, adding q modulo 2^COEF_W
  // yields q - (b - a), which lies in [1, q)
  always_comb begin
    w_diff = {1'b0, i_a} - {1'b0, i_b};
    if (w_diff[COEF_W]) begin
      w_res = w_diff[COEF_W-1:0] + Q;
    end else begin
      w_res = w_diff[COEF_W-1:0];
    end
  end

  // Result register (data path only, intentionally not reset)
  always_ff @(posedge clk) begin
    r_y <= w_res;
  end

  assign o_y = r_y;

endmodule

// File: rtl/polysub_sequencer.sv
// Element-wise C[k] = (A[k] - B[k]) mod q sequencer. Streams addresses
// 0..len_m1 to the A/B banks, delays valid/address by RD_LAT+1 cycles to
// line up with the subtractor output register, then pulses done.
// Optional feature macro: POLYSUB_SWAP_EN (adds a swap input selecting B - A).
module polysub_sequencer #(
  parameter int MOD_INDEX = 0,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  polysub_sequencer_if.slave  bus
);

  import ntt_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [ADDR_W-1:0]  r_len_m1;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_rd_en;
  logic               r_busy;
  logic               r_done;
  logic [RD_LAT:0]    r_vld;
  logic [ADDR_W-1:0]  r_addr_pipe [RD_LAT+1];
  logic               w_pipe_head_empty;
  logic [COEF_W-1:0]  w_op_a;
  logic [COEF_W-1:0]  w_op_b;
  logic [COEF_W-1:0]  w_sub_y;
`ifdef POLYSUB_SWAP_EN
  logic               r_swap;
`endif

  // Only the tail of the valid pipe may still be set when the last write
  // is on the bus; everything ahead of it must have drained
  always_comb begin
    w_pipe_head_empty = 1'b0;
    if (r_vld[RD_LAT-1:0] == '0) begin
      w_pipe_head_empty = 1'b1;
    end else begin
      w_pipe_head_empty = 1'b0;
    end
  end

  // Control FSM: accept start, issue reads in order, drain, pulse done.
  // The read address doubles as the issue counter; it is compared against
  // len_m1 before incrementing so a full-range vector never wraps early.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_len_m1  <= '0;
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef POLYSUB_SWAP_EN
      r_swap    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state   <= ST_ISSUE;
            r_len_m1  <= bus.len_m1;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b1;
            r_busy    <= 1'b1;
`ifdef POLYSUB_SWAP_EN
            r_swap    <= bus.swap;
`endif
          end else begin
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (r_rd_addr == r_len_m1) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_ONE;
            r_rd_en   <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_pipe_head_empty) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Valid/address delay line: stage RD_LAT lines up with the subtractor output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        r_addr_pipe[i] <= '0;
      end
    end else begin
      r_vld          <= {r_vld[RD_LAT-1:0], r_rd_en};
      r_addr_pipe[0] <= r_rd_addr;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
    end
  end

  // Operand routing into the subtractor
  always_comb begin
    w_op_a = bus.a_data;
    w_op_b = bus.b_data;
`ifdef POLYSUB_SWAP_EN
    if (r_swap) begin
      w_op_a = bus.b_data;
      w_op_b = bus.a_data;
    end else begin
      w_op_a = bus.a_data;
      w_op_b = bus.b_data;
    end
`endif
  end

  modular_subtractor #(
    .MOD_INDEX (MOD_INDEX)
  ) u_sub (
    .clk (clk),
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_y (w_sub_y)
  );

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.wr_en   = r_vld[RD_LAT];
  assign bus.wr_addr = r_addr_pipe[RD_LAT];
  assign bus.wr_data = w_sub_y;

endmodule
